reg_alu_pipe: RTL and testbench

Parametrised successor to the 16-bit, 8-entry register file with ALU write-back. Adds configurable data width and register count, a registered write-back stage with operand forwarding, per-command valid qualification, and registered carry and zero flags. It is the datapath core for the multi-cycle processor labs: the controller issues one command per cycle and reads operands and flags back.

---
 rtl/reg_alu_pipe.sv | 92 +++++++++
 tb/tb_reg_alu_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_alu_pipe.sv
// Parametrised register file with a combinational ALU, a registered write-back
// stage with operand forwarding, and registered result, carry and zero flags.
module reg_alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             sel,
    input  logic             wr,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             cout,
    output logic             zero
);
    localparam int NREG = 1 << AW;

    logic [WIDTH-1:0] rf [NREG];
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu;
    logic             r0_a, r0_b;

    // A hard-wired r0 wins over a forwarded value aimed at address 0.
    assign r0_a = (ZERO_R0 != 0) && (rd_addr_a == '0);
    assign r0_b = (ZERO_R0 != 0) && (rd_addr_b == '0);

    assign d_out_a = r0_a ? '0 :
                     (wb_valid && wb_addr == rd_addr_a) ? wb_data : rf[rd_addr_a];
    assign d_out_b = r0_b ? '0 :
                     (wb_valid && wb_addr == rd_addr_b) ? wb_data : rf[rd_addr_b];

    always_comb begin
        sum = '0;
        case (op)
            2'b00:   sum = {1'b0, d_out_a} + {1'b0, d_out_b};
            2'b01:   sum = {1'b0, d_out_a} + {1'b0, ~d_out_b} + {{WIDTH{1'b0}}, 1'b1};
            2'b10:   sum = {1'b0, d_out_a & d_out_b};
            default: sum = {1'b0, d_out_a | d_out_b};
        endcase
    end
    assign alu = sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_valid && !((ZERO_R0 != 0) && (wb_addr == '0))) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= in_valid && wr;
            if (in_valid && wr) begin
                wb_addr <= wr_addr;
                wb_data <= sel ? alu : d_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res       <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= in_valid && sel;
            if (in_valid && sel) begin
                res  <= alu;
                cout <= sum[WIDTH];
                zero <= (alu == '0);
            end
        end
    end
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed bench for reg_alu_pipe: a default instance driven from a vector
// table, plus an 8-bit/16-register instance with a hard-wired r0.
module tb_reg_alu_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, sel, wr;
    logic [1:0]  op;
    logic [3:0]  ra, rb, wa;
    logic [15:0] din;

    logic [15:0] d_out_a, d_out_b, res;
    logic        res_valid, cout, zero;
    logic [7:0]  za, zb, zres;
    logic        zrv, zcout, zzero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_alu_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sel(sel), .wr(wr), .op(op),
        .rd_addr_a(ra[2:0]), .rd_addr_b(rb[2:0]), .wr_addr(wa[2:0]), .d_in(din),
        .d_out_a(d_out_a), .d_out_b(d_out_b), .res(res), .res_valid(res_valid),
        .cout(cout), .zero(zero)
    );

    reg_alu_pipe #(.WIDTH(8), .AW(4), .ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sel(sel), .wr(wr), .op(op),
        .rd_addr_a(ra), .rd_addr_b(rb), .wr_addr(wa), .d_in(din[7:0]),
        .d_out_a(za), .d_out_b(zb), .res(zres), .res_valid(zrv),
        .cout(zcout), .zero(zzero)
    );

    typedef struct {
        logic        v, s, w;
        logic [1:0]  op;
        logic [3:0]  ra, rb, wa;
        logic [15:0] din, ea, eb, eres;
        logic        ec, ez, erv;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, s, w, input logic [1:0] o,
                         input logic [3:0] a, b, d, input logic [15:0] data);
        in_valid = v; sel = s; wr = w; op = o; ra = a; rb = b; wa = d; din = data;
    endtask

    // Operands are checked before the edge, registered outputs just after it.
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.v, t.s, t.w, t.op, t.ra, t.rb, t.wa, t.din);
        #1;
        chk({tag, ".d_out_a"}, d_out_a, t.ea);
        chk({tag, ".d_out_b"}, d_out_b, t.eb);
        @(posedge clk);
        #1;
        chk({tag, ".res"}, res, t.eres);
        chk({tag, ".cout"}, {15'd0, cout}, {15'd0, t.ec});
        chk({tag, ".zero"}, {15'd0, zero}, {15'd0, t.ez});
        chk({tag, ".res_valid"}, {15'd0, res_valid}, {15'd0, t.erv});
    endtask

    initial begin
        //         v  s  w  op    ra rb wa din       d_out_a   d_out_b   res       c  z  rv
        tbl[0]  = '{1, 0, 1, 2'd0, 1, 2, 1, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 2'd0, 1, 2, 2, 16'h0001, 16'h00FF, 16'h0000, 16'h0000, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 2'd0, 1, 2, 3, 16'h0000, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 1};
        tbl[3]  = '{1, 1, 1, 2'd1, 3, 2, 4, 16'h0000, 16'h0100, 16'h0001, 16'h00FF, 1, 0, 1};
        tbl[4]  = '{1, 0, 1, 2'd0, 4, 3, 1, 16'hFFFF, 16'h00FF, 16'h0100, 16'h00FF, 1, 0, 0};
        tbl[5]  = '{1, 1, 1, 2'd0, 1, 2, 5, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 1};
        tbl[6]  = '{1, 1, 1, 2'd1, 2, 1, 6, 16'h0000, 16'h0001, 16'hFFFF, 16'h0002, 0, 0, 1};
        tbl[7]  = '{0, 1, 1, 2'd0, 6, 1, 1, 16'h0000, 16'h0002, 16'hFFFF, 16'h0002, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 2'd0, 1, 6, 0, 16'h0000, 16'hFFFF, 16'h0002, 16'h0002, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 2'd2, 1, 3, 0, 16'h0000, 16'hFFFF, 16'h0100, 16'h0100, 0, 0, 1};
        tbl[10] = '{1, 1, 0, 2'd3, 5, 5, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1};
        tbl[11] = '{1, 0, 1, 2'd0, 7, 7, 7, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0};
        tbl[12] = '{1, 0, 1, 2'd0, 7, 2, 7, 16'h5555, 16'hAAAA, 16'h0001, 16'h0000, 0, 1, 0};
        tbl[13] = '{1, 0, 0, 2'd0, 7, 7, 0, 16'h0000, 16'h5555, 16'h5555, 16'h0000, 0, 1, 0};
        tbl[14] = '{0, 0, 0, 2'd0, 7, 1, 0, 16'h0000, 16'h5555, 16'hFFFF, 16'h0000, 0, 1, 0};

        drive(0, 0, 0, 2'd0, 0, 0, 0, 16'h0);
        reset = 1'b0;
        #1;
        chk("rst.res", res, 16'h0);
        chk("rst.flags", {13'd0, cout, zero, res_valid}, 16'h0);
        chk("rst.d_out_a", d_out_a, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // r3 <= 0x1234, then an add leaves a write-back to r2 pending at reset.
        run_vec('{1, 0, 1, 2'd0, 3, 1, 3, 16'h1234, 16'h0100, 16'hFFFF, 16'h0000, 0, 1, 0}, "h1");
        run_vec('{1, 1, 1, 2'd0, 3, 1, 2, 16'h0000, 16'h1234, 16'hFFFF, 16'h1233, 1, 0, 1}, "h2");
        @(negedge clk);
        drive(0, 0, 0, 2'd0, 3, 1, 0, 16'h0);
        #2 reset = 1'b0;
        #1;
        chk("arst.d_out_a", d_out_a, 16'h0);
        chk("arst.d_out_b", d_out_b, 16'h0);
        chk("arst.res", res, 16'h0);
        chk("arst.cout", {15'd0, cout}, 16'h0);
        chk("arst.zero", {15'd0, zero}, 16'h0);
        chk("arst.res_valid", {15'd0, res_valid}, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        run_vec('{0, 0, 0, 2'd0, 2, 3, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0}, "h3");
        run_vec('{0, 0, 0, 2'd0, 2, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0}, "h4");

        // Hard-wired r0 and top-of-file registers on the 8-bit instance.
        @(negedge clk);
        drive(1, 0, 1, 2'd0, 0, 0, 0, 16'h00CD);
        @(negedge clk);
        drive(1, 0, 1, 2'd0, 0, 0, 15, 16'h0080);
        #1 chk("z.r0_fwd", {8'd0, za}, 16'h0);
        @(negedge clk);
        drive(1, 0, 1, 2'd0, 0, 15, 14, 16'h0080);
        #1 chk("z.r0_rf", {8'd0, za}, 16'h0);
        chk("z.r15_fwd", {8'd0, zb}, 16'h0080);
        @(negedge clk);
        drive(1, 1, 0, 2'd0, 15, 14, 0, 16'h0000);
        #1 chk("z.a15", {8'd0, za}, 16'h0080);
        chk("z.b14", {8'd0, zb}, 16'h0080);
        @(posedge clk);
        #1 chk("z.res", {8'd0, zres}, 16'h0);
        chk("z.cout", {15'd0, zcout}, 16'h1);
        chk("z.zero", {15'd0, zzero}, 16'h1);
        chk("z.res_valid", {15'd0, zrv}, 16'h1);
        @(negedge clk);
        drive(0, 0, 0, 2'd0, 0, 0, 0, 16'h0);
        #1 chk("z.r0_late", {8'd0, za}, 16'h0);
        chk("z.rv_drop", {15'd0, zrv}, 16'h1);
        @(posedge clk);
        #1 chk("z.rv_idle", {15'd0, zrv}, 16'h0);
        chk("z.res_hold", {8'd0, zres}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
